// File: rtl/mmu_port_arbiter.sv
// mmu_port_arbiter
// Shares the single MMU load/store port between instruction fetch (read only)
// and the LSU (read + write). Requests are issued as one-cycle registered
// pulses. A small ID FIFO remembers who owns each in-flight read so the
// in-order MMU responses can be steered back combinationally. A write is
// only issued with no reads in flight, and nothing issues until it completes.
// Build option: define MMU_ARB_LSU_PRIORITY_EN to give the LSU fixed priority
// over fetch. Without it, arbitration is round-robin on a last-grant pointer.
module mmu_port_arbiter #(
    parameter int MAX_RD_OUTSTANDING = 4
) (
    input  logic        mmu_clk,
    input  logic        i_rstn,
    // fetch read
    input  logic        if_rd_req,
    input  logic [31:0] if_rd_addr,
    output logic        if_rd_ack,
    output logic        if_rd_valid,
    output logic [31:0] if_rd_data,
    // LSU read
    input  logic        ls_rd_req,
    input  logic [31:0] ls_rd_addr,
    input  logic [4:0]  ls_rd_reg,
    input  logic [2:0]  ls_rd_func3,
    output logic        ls_rd_ack,
    output logic        ls_rd_valid,
    output logic [31:0] ls_rd_data,
    output logic [4:0]  ls_rd_valid_reg,
    output logic [2:0]  ls_rd_valid_func3,
    // LSU write
    input  logic        ls_wr_req,
    input  logic [31:0] ls_wr_addr,
    input  logic [31:0] ls_wr_data,
    input  logic [2:0]  ls_wr_func3,
    output logic        ls_wr_ack,
    output logic        ls_wr_done,
    // MMU read
    output logic        mmu_rd_req,
    output logic [31:0] mmu_rd_addr,
    output logic [4:0]  mmu_rd_req_reg,
    output logic [2:0]  mmu_rd_req_func3,
    input  logic        mmu_rd_valid,
    input  logic [31:0] mmu_rd_data,
    input  logic [4:0]  mmu_rd_valid_reg,
    input  logic [2:0]  mmu_rd_valid_func3,
    // MMU write
    output logic        mmu_wr_req,
    output logic [31:0] mmu_wr_addr,
    output logic [31:0] mmu_wr_data,
    output logic [2:0]  mmu_wr_req_func3,
    input  logic        mmu_wr_done,
    // sticky protocol error
    output logic        arb_err
);

    localparam int PTR_W = $clog2(MAX_RD_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, WR_WAIT} state_t;

    state_t                        state_q, state_d;
    logic [MAX_RD_OUTSTANDING-1:0] id_fifo;     // 0 = fetch, 1 = LSU
    logic [PTR_W-1:0]              rd_ptr, wr_ptr;
    logic [CNT_W-1:0]              count;

    logic f_elig, l_elig, l_is_wr;
    logic rd_room, wr_room, f_can, l_can;
    logic grant_f, grant_l;
    logic fifo_empty, head_id, push, pop;
    logic rd_err, wr_err;

    // a requester being acked this cycle is still showing its old request
    assign f_elig  = if_rd_req & ~if_rd_ack;
    assign l_elig  = (ls_wr_req | ls_rd_req) & ~ls_rd_ack & ~ls_wr_ack;
    assign l_is_wr = ls_wr_req;  // LSU write beats LSU read

    // a pop in the same cycle does not free a slot: only registered count is used
    assign fifo_empty = (count == '0);
    assign rd_room    = (state_q == IDLE) && (count < CNT_W'(MAX_RD_OUTSTANDING));
    assign wr_room    = (state_q == IDLE) && fifo_empty;
    assign f_can      = f_elig & rd_room;
    assign l_can      = l_elig & (l_is_wr ? wr_room : rd_room);

`ifdef MMU_ARB_LSU_PRIORITY_EN
    assign grant_l = l_can;
`else
    logic last_l;  // 1 = LSU was granted last
    assign grant_l = l_can & (~f_can | ~last_l);
`endif
    assign grant_f = f_can & ~grant_l;

    // response steering: head of the ID FIFO owns the current response
    assign head_id = id_fifo[rd_ptr];
    assign pop     = mmu_rd_valid & ~fifo_empty;
    assign push    = grant_f | (grant_l & ~l_is_wr);
    assign rd_err  = mmu_rd_valid & fifo_empty;

    assign if_rd_valid       = pop & ~head_id;
    assign ls_rd_valid       = pop & head_id;
    assign if_rd_data        = mmu_rd_data;
    assign ls_rd_data        = mmu_rd_data;
    assign ls_rd_valid_reg   = mmu_rd_valid_reg;
    assign ls_rd_valid_func3 = mmu_rd_valid_func3;

    // state register
    always_ff @(posedge mmu_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // next state, write completion and stray-completion detection
    always_comb begin
        state_d    = state_q;
        ls_wr_done = 1'b0;
        wr_err     = 1'b0;
        case (state_q)
            IDLE: begin
                wr_err = mmu_wr_done;
                if (grant_l && l_is_wr) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                ls_wr_done = mmu_wr_done;
                if (mmu_wr_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // registered issue: request pulse, payload and ack all land in cycle N+1
    always_ff @(posedge mmu_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mmu_rd_req       <= 1'b0;
            mmu_rd_addr      <= '0;
            mmu_rd_req_reg   <= '0;
            mmu_rd_req_func3 <= '0;
            mmu_wr_req       <= 1'b0;
            mmu_wr_addr      <= '0;
            mmu_wr_data      <= '0;
            mmu_wr_req_func3 <= '0;
            if_rd_ack        <= 1'b0;
            ls_rd_ack        <= 1'b0;
            ls_wr_ack        <= 1'b0;
        end else begin
            mmu_rd_req <= 1'b0;
            mmu_wr_req <= 1'b0;
            if_rd_ack  <= 1'b0;
            ls_rd_ack  <= 1'b0;
            ls_wr_ack  <= 1'b0;
            if (grant_f) begin
                mmu_rd_req       <= 1'b1;
                mmu_rd_addr      <= if_rd_addr;
                mmu_rd_req_reg   <= 5'd0;
                mmu_rd_req_func3 <= 3'b010;  // fetch is always a word read
                if_rd_ack        <= 1'b1;
            end else if (grant_l && !l_is_wr) begin
                mmu_rd_req       <= 1'b1;
                mmu_rd_addr      <= ls_rd_addr;
                mmu_rd_req_reg   <= ls_rd_reg;
                mmu_rd_req_func3 <= ls_rd_func3;
                ls_rd_ack        <= 1'b1;
            end else if (grant_l) begin
                mmu_wr_req       <= 1'b1;
                mmu_wr_addr      <= ls_wr_addr;
                mmu_wr_data      <= ls_wr_data;
                mmu_wr_req_func3 <= ls_wr_func3;
                ls_wr_ack        <= 1'b1;
            end
        end
    end

    // in-flight read ID FIFO
    always_ff @(posedge mmu_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            id_fifo <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= grant_l;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifndef MMU_ARB_LSU_PRIORITY_EN
    // round-robin pointer, starts at LSU so fetch wins the first contention
    always_ff @(posedge mmu_clk or negedge i_rstn) begin
        if (!i_rstn)      last_l <= 1'b1;
        else if (grant_f) last_l <= 1'b0;
        else if (grant_l) last_l <= 1'b1;
    end
`endif

    // sticky protocol error, cleared only by reset
    always_ff @(posedge mmu_clk or negedge i_rstn) begin
        if (!i_rstn)               arb_err <= 1'b0;
        else if (rd_err || wr_err) arb_err <= 1'b1;
    end

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Bench for mmu_port_arbiter: reset checks, a table of single-transaction
// vectors, directed multi-cycle sequences, then random traffic against a
// queue-based reference model.
module tb_mmu_port_arbiter;

    localparam int MAXO = 4;

    logic        mmu_clk = 1'b0;
    logic        i_rstn;
    logic        if_rd_req, if_rd_ack, if_rd_valid;
    logic [31:0] if_rd_addr, if_rd_data;
    logic        ls_rd_req, ls_rd_ack, ls_rd_valid;
    logic [31:0] ls_rd_addr, ls_rd_data;
    logic [4:0]  ls_rd_reg, ls_rd_valid_reg;
    logic [2:0]  ls_rd_func3, ls_rd_valid_func3;
    logic        ls_wr_req, ls_wr_ack, ls_wr_done;
    logic [31:0] ls_wr_addr, ls_wr_data;
    logic [2:0]  ls_wr_func3;
    logic        mmu_rd_req, mmu_rd_valid;
    logic [31:0] mmu_rd_addr, mmu_rd_data;
    logic [4:0]  mmu_rd_req_reg, mmu_rd_valid_reg;
    logic [2:0]  mmu_rd_req_func3, mmu_rd_valid_func3;
    logic        mmu_wr_req, mmu_wr_done;
    logic [31:0] mmu_wr_addr, mmu_wr_data;
    logic [2:0]  mmu_wr_req_func3;
    logic        arb_err;

    mmu_port_arbiter #(.MAX_RD_OUTSTANDING(MAXO)) dut (
        .mmu_clk(mmu_clk), .i_rstn(i_rstn),
        .if_rd_req(if_rd_req), .if_rd_addr(if_rd_addr), .if_rd_ack(if_rd_ack),
        .if_rd_valid(if_rd_valid), .if_rd_data(if_rd_data),
        .ls_rd_req(ls_rd_req), .ls_rd_addr(ls_rd_addr), .ls_rd_reg(ls_rd_reg),
        .ls_rd_func3(ls_rd_func3), .ls_rd_ack(ls_rd_ack), .ls_rd_valid(ls_rd_valid),
        .ls_rd_data(ls_rd_data), .ls_rd_valid_reg(ls_rd_valid_reg),
        .ls_rd_valid_func3(ls_rd_valid_func3),
        .ls_wr_req(ls_wr_req), .ls_wr_addr(ls_wr_addr), .ls_wr_data(ls_wr_data),
        .ls_wr_func3(ls_wr_func3), .ls_wr_ack(ls_wr_ack), .ls_wr_done(ls_wr_done),
        .mmu_rd_req(mmu_rd_req), .mmu_rd_addr(mmu_rd_addr),
        .mmu_rd_req_reg(mmu_rd_req_reg), .mmu_rd_req_func3(mmu_rd_req_func3),
        .mmu_rd_valid(mmu_rd_valid), .mmu_rd_data(mmu_rd_data),
        .mmu_rd_valid_reg(mmu_rd_valid_reg), .mmu_rd_valid_func3(mmu_rd_valid_func3),
        .mmu_wr_req(mmu_wr_req), .mmu_wr_addr(mmu_wr_addr), .mmu_wr_data(mmu_wr_data),
        .mmu_wr_req_func3(mmu_wr_req_func3), .mmu_wr_done(mmu_wr_done),
        .arb_err(arb_err)
    );

    always #5 mmu_clk = ~mmu_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge mmu_clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_rd_req = 0; if_rd_addr = 0;
        ls_rd_req = 0; ls_rd_addr = 0; ls_rd_reg = 0; ls_rd_func3 = 0;
        ls_wr_req = 0; ls_wr_addr = 0; ls_wr_data = 0; ls_wr_func3 = 0;
        mmu_rd_valid = 0; mmu_rd_data = 0; mmu_rd_valid_reg = 0; mmu_rd_valid_func3 = 0;
        mmu_wr_done = 0;
    endtask

    task automatic do_reset();
        i_rstn = 0;
        clear_inputs();
        tick();
        tick();
        i_rstn = 1;
    endtask

    // ---------------- reference model (random phase) ----------------
    logic        m_rd_req, m_wr_req, m_fa, m_lra, m_lwa, m_err, m_wr_busy, m_last_l;
    logic [31:0] m_rd_addr, m_wr_addr, m_wr_data;
    logic [4:0]  m_rd_reg;
    logic [2:0]  m_rd_f3, m_wr_f3;
    bit          q[$];  // owners of in-flight reads, oldest first

    task automatic model_reset();
        {m_rd_req, m_wr_req, m_fa, m_lra, m_lwa, m_err, m_wr_busy} = '0;
        m_last_l = 1;
        m_rd_addr = 0; m_wr_addr = 0; m_wr_data = 0;
        m_rd_reg = 0; m_rd_f3 = 0; m_wr_f3 = 0;
        q.delete();
    endtask

    task automatic model_check();
        logic pv;
        pv = mmu_rd_valid && (q.size() > 0);
        chk("mmu_rd_req", mmu_rd_req, m_rd_req);
        chk("mmu_wr_req", mmu_wr_req, m_wr_req);
        chk("if_rd_ack", if_rd_ack, m_fa);
        chk("ls_rd_ack", ls_rd_ack, m_lra);
        chk("ls_wr_ack", ls_wr_ack, m_lwa);
        chk("mmu_rd_addr", mmu_rd_addr, m_rd_addr);
        chk("mmu_rd_req_reg", mmu_rd_req_reg, m_rd_reg);
        chk("mmu_rd_req_func3", mmu_rd_req_func3, m_rd_f3);
        chk("mmu_wr_addr", mmu_wr_addr, m_wr_addr);
        chk("mmu_wr_data", mmu_wr_data, m_wr_data);
        chk("mmu_wr_req_func3", mmu_wr_req_func3, m_wr_f3);
        chk("if_rd_valid", if_rd_valid, pv && (q[0] == 1'b0));
        chk("ls_rd_valid", ls_rd_valid, pv && (q[0] == 1'b1));
        chk("ls_wr_done", ls_wr_done, m_wr_busy && mmu_wr_done);
        chk("arb_err", arb_err, m_err);
        chk("if_rd_data", if_rd_data, mmu_rd_data);
        chk("ls_rd_valid_reg", ls_rd_valid_reg, mmu_rd_valid_reg);
    endtask

    task automatic model_step();
        logic f_ok, l_ok, rd_room, wr_room, f_can, l_can, gf, gl;
        f_ok    = if_rd_req && !m_fa;
        l_ok    = (ls_wr_req || ls_rd_req) && !m_lra && !m_lwa;
        rd_room = !m_wr_busy && (q.size() < MAXO);
        wr_room = !m_wr_busy && (q.size() == 0);
        f_can   = f_ok && rd_room;
        l_can   = l_ok && (ls_wr_req ? wr_room : rd_room);
`ifdef MMU_ARB_LSU_PRIORITY_EN
        gl = l_can;
`else
        gl = l_can && (!f_can || !m_last_l);
`endif
        gf = f_can && !gl;
        if (mmu_rd_valid) begin
            if (q.size() > 0) void'(q.pop_front());
            else m_err = 1;
        end
        if (mmu_wr_done) begin
            if (m_wr_busy) m_wr_busy = 0;
            else m_err = 1;
        end
        {m_rd_req, m_wr_req, m_fa, m_lra, m_lwa} = '0;
        if (gf) begin
            m_rd_req = 1; m_fa = 1; m_last_l = 0;
            m_rd_addr = if_rd_addr; m_rd_reg = 0; m_rd_f3 = 3'b010;
            q.push_back(1'b0);
        end
        if (gl) begin
            m_last_l = 1;
            if (ls_wr_req) begin
                m_wr_req = 1; m_lwa = 1; m_wr_busy = 1;
                m_wr_addr = ls_wr_addr; m_wr_data = ls_wr_data; m_wr_f3 = ls_wr_func3;
            end else begin
                m_rd_req = 1; m_lra = 1;
                m_rd_addr = ls_rd_addr; m_rd_reg = ls_rd_reg; m_rd_f3 = ls_rd_func3;
                q.push_back(1'b1);
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        f, lr, lw;
        logic [31:0] faddr, laddr, wdata;
        logic [4:0]  rreg;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic        e_rd, e_wr;
        logic [31:0] e_addr;
        logic [4:0]  e_reg;
        logic [2:0]  e_f3;
        logic        e_fa, e_lra, e_lwa, e_ifv, e_lsv;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] d;
        logic [4:0]  r;
        logic [2:0]  f;
    } rsp_t;

    initial begin
        vec_t vt[6];
        rsp_t rq[$];
        rsp_t rs;
        int   last_due, wr_due, d;

        // reset state
        i_rstn = 0;
        clear_inputs();
        #2;
        chk("rst mmu_rd_req", mmu_rd_req, 0);
        chk("rst mmu_wr_req", mmu_wr_req, 0);
        chk("rst acks", {if_rd_ack, ls_rd_ack, ls_wr_ack}, 0);
        chk("rst valids", {if_rd_valid, ls_rd_valid, ls_wr_done}, 0);
        chk("rst arb_err", arb_err, 0);
        chk("rst mmu_rd_addr", mmu_rd_addr, 0);
        tick(); tick();
        i_rstn = 1;

        //        f  lr lw faddr    laddr    wdata          reg f3      rdata          rd wr e_addr   reg f3      fa lra lwa ifv lsv
        vt[0] = '{1, 0, 0, 32'h100, 32'h0,   32'h0,         0,  3'b000, 32'hDEADBEEF, 1, 0, 32'h100, 0,  3'b010, 1, 0,  0,  1,  0};
        vt[1] = '{0, 1, 0, 32'h0,   32'h340, 32'h0,         7,  3'b100, 32'hCAFE0001, 1, 0, 32'h340, 7,  3'b100, 0, 1,  0,  0,  1};
        vt[2] = '{0, 0, 1, 32'h0,   32'h200, 32'h12345678,  0,  3'b010, 32'h0,        0, 1, 32'h200, 0,  3'b010, 0, 0,  1,  0,  0};
`ifdef MMU_ARB_LSU_PRIORITY_EN
        vt[3] = '{1, 1, 0, 32'h400, 32'h500, 32'h0,         3,  3'b001, 32'h0BADF00D, 1, 0, 32'h500, 3,  3'b001, 0, 1,  0,  0,  1};
`else
        vt[3] = '{1, 1, 0, 32'h400, 32'h500, 32'h0,         3,  3'b001, 32'h0BADF00D, 1, 0, 32'h400, 0,  3'b010, 1, 0,  0,  1,  0};
`endif
        vt[4] = '{1, 0, 1, 32'h600, 32'h700, 32'hA5A5A5A5,  0,  3'b001, 32'h0,        0, 1, 32'h700, 0,  3'b001, 0, 0,  1,  0,  0};
        vt[5] = '{0, 1, 1, 32'h0,   32'h800, 32'h55AA55AA,  9,  3'b000, 32'h0,        0, 1, 32'h800, 0,  3'b000, 0, 0,  1,  0,  0};

        for (int i = 0; i < 6; i++) begin
            if_rd_req = vt[i].f;  if_rd_addr = vt[i].faddr;
            ls_rd_req = vt[i].lr; ls_rd_addr = vt[i].laddr; ls_rd_reg = vt[i].rreg; ls_rd_func3 = vt[i].f3;
            ls_wr_req = vt[i].lw; ls_wr_addr = vt[i].laddr; ls_wr_data = vt[i].wdata; ls_wr_func3 = vt[i].f3;
            tick();
            if_rd_req = 0; ls_rd_req = 0; ls_wr_req = 0;
            #1;
            chk($sformatf("v%0d mmu_rd_req", i), mmu_rd_req, vt[i].e_rd);
            chk($sformatf("v%0d mmu_wr_req", i), mmu_wr_req, vt[i].e_wr);
            chk($sformatf("v%0d acks", i), {if_rd_ack, ls_rd_ack, ls_wr_ack}, {vt[i].e_fa, vt[i].e_lra, vt[i].e_lwa});
            if (vt[i].e_rd) begin
                chk($sformatf("v%0d rd_addr", i), mmu_rd_addr, vt[i].e_addr);
                chk($sformatf("v%0d rd_reg", i), mmu_rd_req_reg, vt[i].e_reg);
                chk($sformatf("v%0d rd_func3", i), mmu_rd_req_func3, vt[i].e_f3);
            end else begin
                chk($sformatf("v%0d wr_addr", i), mmu_wr_addr, vt[i].e_addr);
                chk($sformatf("v%0d wr_data", i), mmu_wr_data, vt[i].wdata);
                chk($sformatf("v%0d wr_func3", i), mmu_wr_req_func3, vt[i].e_f3);
            end
            tick();
            mmu_rd_valid = vt[i].e_rd; mmu_rd_data = vt[i].rdata;
            mmu_wr_done  = vt[i].e_wr;
            #1;
            chk($sformatf("v%0d req pulse ends", i), {mmu_rd_req, mmu_wr_req}, 0);
            chk($sformatf("v%0d rd valids", i), {if_rd_valid, ls_rd_valid}, {vt[i].e_ifv, vt[i].e_lsv});
            chk($sformatf("v%0d ls_wr_done", i), ls_wr_done, vt[i].e_wr);
            if (vt[i].e_ifv) chk($sformatf("v%0d if_rd_data", i), if_rd_data, vt[i].rdata);
            tick();
            clear_inputs();
        end
        chk("table arb_err", arb_err, 0);

        // write held behind two outstanding reads, reads held behind write
        if_rd_req = 1; if_rd_addr = 32'h10;
        tick();
        if_rd_req = 0; ls_rd_req = 1; ls_rd_addr = 32'h20; ls_rd_reg = 5;
        tick();
        ls_rd_req = 0;
        ls_wr_req = 1; ls_wr_addr = 32'h200; ls_wr_data = 32'h12345678; ls_wr_func3 = 3'b010;
        tick(); #1;
        chk("A wr held c3", mmu_wr_req, 0);
        tick();
        mmu_rd_valid = 1; mmu_rd_data = 32'hA; #1;
        chk("A rsp1 routing", {if_rd_valid, ls_rd_valid}, 2'b10);
        chk("A wr held c4", mmu_wr_req, 0);
        tick();
        mmu_rd_valid = 1; mmu_rd_data = 32'hB; #1;
        chk("A rsp2 routing", {if_rd_valid, ls_rd_valid}, 2'b01);
        tick();
        mmu_rd_valid = 0; #1;
        chk("A wr held c6", mmu_wr_req, 0);
        tick();
        chk("A wr issued", {mmu_wr_req, ls_wr_ack}, 2'b11);
        chk("A wr payload", mmu_wr_data, 32'h12345678);
        chk("A wr addr", mmu_wr_addr, 32'h200);
        ls_wr_req = 0; if_rd_req = 1; if_rd_addr = 32'h30;
        tick(); #1;
        chk("A rd blocked c8", mmu_rd_req, 0);
        tick();
        mmu_wr_done = 1; #1;
        chk("A ls_wr_done", ls_wr_done, 1);
        chk("A rd blocked c9", mmu_rd_req, 0);
        tick();
        mmu_wr_done = 0; #1;
        chk("A ls_wr_done pulse", ls_wr_done, 0);
        chk("A rd blocked c10", mmu_rd_req, 0);
        tick();
        chk("A rd after done", {mmu_rd_req, if_rd_ack}, 2'b11);
        if_rd_req = 0;
        tick();
        mmu_rd_valid = 1; #1;
        chk("A rsp3 routing", {if_rd_valid, ls_rd_valid}, 2'b10);
        tick();
        clear_inputs();

        // LSU write and read together: write first, read after completion
        ls_wr_req = 1; ls_wr_addr = 32'h900; ls_rd_req = 1; ls_rd_addr = 32'h904;
        tick(); #1;
        chk("B write acked first", {ls_wr_ack, ls_rd_ack, mmu_wr_req}, 3'b101);
        ls_wr_req = 0;
        tick(); #1;
        chk("B rd blocked", mmu_rd_req, 0);
        tick();
        mmu_wr_done = 1; #1;
        chk("B ls_wr_done", ls_wr_done, 1);
        tick();
        mmu_wr_done = 0; #1;
        chk("B rd not yet", mmu_rd_req, 0);
        tick();
        chk("B rd issued", {mmu_rd_req, ls_rd_ack}, 2'b11);
        chk("B rd addr", mmu_rd_addr, 32'h904);
        ls_rd_req = 0;
        tick();
        mmu_rd_valid = 1; #1;
        chk("B rsp routing", {if_rd_valid, ls_rd_valid}, 2'b01);
        tick();
        clear_inputs(); #1;
        chk("B arb_err clean", arb_err, 0);

        // spurious response with empty FIFO
        mmu_rd_valid = 1; #1;
        chk("C spurious no valid", {if_rd_valid, ls_rd_valid}, 0);
        tick();
        mmu_rd_valid = 0; #1;
        chk("C arb_err set", arb_err, 1);
        tick(); tick(); #1;
        chk("C arb_err sticky", arb_err, 1);
        i_rstn = 0; #1;
        chk("C arb_err cleared", arb_err, 0);
        tick(); i_rstn = 1;
        // stray write completion in IDLE
        mmu_wr_done = 1; #1;
        chk("C stray done hidden", ls_wr_done, 0);
        tick();
        mmu_wr_done = 0; #1;
        chk("C arb_err stray done", arb_err, 1);
        do_reset();

        // reset with three reads in flight
        if_rd_req = 1; if_rd_addr = 32'h40;
        tick();
        if_rd_req = 0; ls_rd_req = 1; ls_rd_addr = 32'h44;
        tick();
        ls_rd_req = 0; if_rd_req = 1; if_rd_addr = 32'h48;
        tick();
        if_rd_req = 0; #1;
        chk("D issue before reset", {mmu_rd_req, if_rd_ack}, 2'b11);
        i_rstn = 0; #1;
        chk("D rst reqs", {mmu_rd_req, mmu_wr_req}, 0);
        chk("D rst acks", {if_rd_ack, ls_rd_ack, ls_wr_ack}, 0);
        chk("D rst misc", {if_rd_valid, ls_rd_valid, ls_wr_done, arb_err}, 0);
        chk("D rst addr", mmu_rd_addr, 0);
        tick(); i_rstn = 1;
        tick();
        mmu_rd_valid = 1; mmu_rd_data = 32'h77; #1;
        chk("D late rsp dropped", {if_rd_valid, ls_rd_valid}, 0);
        tick();
        do_reset();

        // random traffic against the reference model
        model_reset();
        last_due = -1;
        wr_due = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (m_fa || !if_rd_req) begin
                if_rd_req  = ($urandom_range(0, 3) != 0);
                if_rd_addr = $urandom;
            end
            if (m_lwa || !ls_wr_req) begin
                ls_wr_req   = ($urandom_range(0, 5) == 0);
                ls_wr_addr  = $urandom;
                ls_wr_data  = $urandom;
                ls_wr_func3 = 3'($urandom);
            end
            if (m_lra || !ls_rd_req) begin
                ls_rd_req   = ($urandom_range(0, 1) == 0);
                ls_rd_addr  = $urandom;
                ls_rd_reg   = 5'($urandom);
                ls_rd_func3 = 3'($urandom);
            end
            if (m_rd_req) begin
                d = cyc + int'($urandom_range(1, 8));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                rs.due = d; rs.d = $urandom; rs.r = m_rd_reg; rs.f = m_rd_f3;
                rq.push_back(rs);
            end
            if (m_wr_req) wr_due = cyc + int'($urandom_range(1, 4));
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                rs = rq.pop_front();
                mmu_rd_valid = 1; mmu_rd_data = rs.d;
                mmu_rd_valid_reg = rs.r; mmu_rd_valid_func3 = rs.f;
            end else begin
                mmu_rd_valid = 0; mmu_rd_data = $urandom;
                mmu_rd_valid_reg = 5'($urandom); mmu_rd_valid_func3 = 3'($urandom);
            end
            mmu_wr_done = (wr_due == cyc);
            if (wr_due == cyc) wr_due = -1;
            #1;
            model_check();
            model_step();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
